// File: rtl/pn_synapse_accum_pkg.sv
// Shared constants and arithmetic helpers for the PN synapse / SOMA / STDP path.
//   PN_ADDR_W   : weight-table address width
//   PN_WEIGHT_W : signed weight width
//   PN_ACC_W    : signed accumulator / synaptic current width
//   PN_DATA_W   : width of the controller data bus
//   sat_add     : signed add clamped to a chosen two's-complement width
package pn_synapse_accum_pkg;

  localparam int unsigned PN_ADDR_W   = 7;
  localparam int unsigned PN_WEIGHT_W = 8;
  localparam int unsigned PN_ACC_W    = 32;
  localparam int unsigned PN_DATA_W   = 32;

  // Working width for saturating arithmetic; wide enough that the raw sum of
  // two in-range operands of any supported width never wraps.
  localparam int unsigned PN_SAT_W = 64;

  // Add two signed values and clamp the result to the range of a signed
  // 'width'-bit number. Operands must already lie in that range and be
  // sign-extended to PN_SAT_W bits; the caller keeps the low 'width' bits.
  function automatic logic signed [PN_SAT_W-1:0] sat_add(
    input logic signed [PN_SAT_W-1:0] a,
    input logic signed [PN_SAT_W-1:0] b,
    input int unsigned                width
  );
    logic signed [PN_SAT_W-1:0] sum;
    logic signed [PN_SAT_W-1:0] max_v;
    logic signed [PN_SAT_W-1:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/pn_synapse_accum_weight_ram.sv
// pn_weight_ram: DEPTH x WIDTH synchronous single-port weight table.
//   clk   in  1       clock
//   rst   in  1       async active-high reset (read register only)
//   we    in  1       write enable: mem[addr] <= wdata
//   re    in  1       read enable: rdata <= mem[addr] at the edge
//   addr  in  ADDR_W  shared read/write address
//   wdata in  WIDTH   write data
//   rdata out WIDTH   registered read data, holds between reads
// Storage is never reset. A simultaneous read and write returns the new data.
module pn_weight_ram #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 2 ** ADDR_W,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Write-first bypass: on a same-cycle write the read returns the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/pn_synapse_accum.sv
// pn_synapse_accum: synapse stage behind the PN controller. Stores weights,
// sums the weights fetched by spike reads into a per-timestep current and
// hands the closed sum to SOMA over a valid/ready handshake.
//   clk             in  1        clock
//   rst             in  1        async active-high reset
//   W_EN2Synapse    in  1        weight write strobe
//   R_EN2Synapse    in  1        weight read (spike) strobe
//   to_Synapse_Addr in  ADDR_W   table address
//   to_Synapse_DATA in  DATA_W   write data, low WEIGHT_W bits used
//   ts_end          in  1        timestep boundary pulse
//   rd_weight       out WEIGHT_W last read weight
//   rd_weight_valid out 1        rd_weight updated this cycle
//   I_syn           out ACC_W    closed timestep current
//   I_syn_valid     out 1        I_syn not yet consumed
//   I_syn_ready     in  1        SOMA accept
//   acc_overrun     out 1        sticky: a closed sum was dropped
module pn_synapse_accum
  import pn_synapse_accum_pkg::*;
#(
  parameter int unsigned ADDR_W   = PN_ADDR_W,
  parameter int unsigned DEPTH    = 2 ** ADDR_W,
  parameter int unsigned WEIGHT_W = PN_WEIGHT_W,
  parameter int unsigned DATA_W   = PN_DATA_W,
  parameter int unsigned ACC_W    = PN_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              W_EN2Synapse,
  input  logic              R_EN2Synapse,
  input  logic [ADDR_W-1:0] to_Synapse_Addr,
  input  logic [DATA_W-1:0] to_Synapse_DATA,
  input  logic              ts_end,
  output logic [WEIGHT_W-1:0] rd_weight,
  output logic              rd_weight_valid,
  output logic [ACC_W-1:0]  I_syn,
  output logic              I_syn_valid,
  input  logic              I_syn_ready,
  output logic              acc_overrun
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    weight_ext;
  logic signed [ACC_W-1:0]    addend;
  logic signed [PN_SAT_W-1:0] acc_wide;
  logic signed [PN_SAT_W-1:0] addend_wide;
  logic signed [PN_SAT_W-1:0] sum_wide;
  logic signed [ACC_W-1:0]    acc_sum;
  logic                       out_free;
  logic                       data_hi_unused;
  logic                       sum_hi_unused;

  // Only the weight field of the data bus is stored.
  assign data_hi_unused = ^to_Synapse_DATA[DATA_W-1:WEIGHT_W];

  pn_weight_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WIDTH  (WEIGHT_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (W_EN2Synapse),
    .re    (R_EN2Synapse),
    .addr  (to_Synapse_Addr),
    .wdata (to_Synapse_DATA[WEIGHT_W-1:0]),
    .rdata (rd_weight)
  );

  // rd_weight_valid marks the cycle in which the fetched weight is presented;
  // that same cycle is when it is folded into the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_weight_valid <= 1'b0;
    end else begin
      rd_weight_valid <= R_EN2Synapse;
    end
  end

  always_comb begin
    weight_ext  = {{(ACC_W - WEIGHT_W){rd_weight[WEIGHT_W-1]}}, rd_weight};
    addend      = rd_weight_valid ? weight_ext : '0;
    acc_wide    = {{(PN_SAT_W - ACC_W){acc[ACC_W-1]}}, acc};
    addend_wide = {{(PN_SAT_W - ACC_W){addend[ACC_W-1]}}, addend};
    sum_wide    = sat_add(acc_wide, addend_wide, ACC_W);
    acc_sum     = sum_wide[ACC_W-1:0];
  end

  // Upper bits are pure sign extension of the clamped result.
  assign sum_hi_unused = ^sum_wide[PN_SAT_W-1:ACC_W];

  // acc_sum already includes a weight presented in the ts_end cycle, so that
  // weight closes into this timestep while a read issued in the ts_end cycle
  // lands in the freshly cleared accumulator one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (ts_end) begin
      acc <= '0;
    end else if (rd_weight_valid) begin
      acc <= acc_sum;
    end
  end

  assign out_free = !I_syn_valid || I_syn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      I_syn       <= '0;
      I_syn_valid <= 1'b0;
      acc_overrun <= 1'b0;
    end else if (ts_end) begin
      if (out_free) begin
        I_syn       <= acc_sum;
        I_syn_valid <= 1'b1;
      end else begin
        acc_overrun <= 1'b1;
      end
    end else if (I_syn_valid && I_syn_ready) begin
      I_syn_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pn_synapse_accum.sv
module tb_pn_synapse_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // Full-width instance
  logic        w_en, r_en, ts_end, ready;
  logic [6:0]  addr;
  logic [31:0] data;
  logic [7:0]  rd_weight;
  logic        rd_valid;
  logic [31:0] i_syn;
  logic        i_valid;
  logic        overrun;

  // Narrow-accumulator instance for saturation boundaries
  logic        s_w, s_r, s_ts, s_ready;
  logic [6:0]  s_addr;
  logic [31:0] s_data;
  logic [7:0]  s_rd_weight;
  logic        s_rd_valid;
  logic [11:0] s_i_syn;
  logic        s_i_valid;
  logic        s_overrun;

  int vectors    = 0;
  int miscompares = 0;

  pn_synapse_accum dut (
    .clk             (clk),
    .rst             (rst),
    .W_EN2Synapse    (w_en),
    .R_EN2Synapse    (r_en),
    .to_Synapse_Addr (addr),
    .to_Synapse_DATA (data),
    .ts_end          (ts_end),
    .rd_weight       (rd_weight),
    .rd_weight_valid (rd_valid),
    .I_syn           (i_syn),
    .I_syn_valid     (i_valid),
    .I_syn_ready     (ready),
    .acc_overrun     (overrun)
  );

  pn_synapse_accum #(.ACC_W(12)) dut_small (
    .clk             (clk),
    .rst             (rst),
    .W_EN2Synapse    (s_w),
    .R_EN2Synapse    (s_r),
    .to_Synapse_Addr (s_addr),
    .to_Synapse_DATA (s_data),
    .ts_end          (s_ts),
    .rd_weight       (s_rd_weight),
    .rd_weight_valid (s_rd_valid),
    .I_syn           (s_i_syn),
    .I_syn_valid     (s_i_valid),
    .I_syn_ready     (s_ready),
    .acc_overrun     (s_overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    w_en = 0; r_en = 0; ts_end = 0; addr = '0; data = '0;
  endtask

  task automatic test_reset;
    rst = 1; ready = 0;
    idle();
    s_w = 0; s_r = 0; s_ts = 0; s_ready = 1; s_addr = '0; s_data = '0;
    #12;
    vectors++; if (rd_weight !== 8'h00) begin miscompares++; $display("FAIL reset_rd_weight got %h exp 00", rd_weight); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    vectors++; if (i_syn !== 32'h0) begin miscompares++; $display("FAIL reset_i_syn got %h exp 0", i_syn); end
    vectors++; if (i_valid !== 1'b0) begin miscompares++; $display("FAIL reset_i_valid got %b exp 0", i_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    vectors++; if (s_i_valid !== 1'b0) begin miscompares++; $display("FAIL reset_small_valid got %b exp 0", s_i_valid); end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  // Write 5@3, -2@4, read back-to-back, close timestep: 5 + -2 = 3
  task automatic test_write_read;
    w_en = 1; addr = 7'd3; data = 32'hABCD_EF05; tick();
    w_en = 1; addr = 7'd4; data = 32'h0000_00FE; tick();
    w_en = 0; r_en = 1; addr = 7'd3; tick();
    vectors++; if (rd_weight !== 8'h05) begin miscompares++; $display("FAIL rd3 got %h exp 05", rd_weight); end
    vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL rd3_valid got %b exp 1", rd_valid); end
    addr = 7'd4; tick();
    vectors++; if (rd_weight !== 8'hFE) begin miscompares++; $display("FAIL rd4 got %h exp fe", rd_weight); end
    r_en = 0; ts_end = 1; tick();
    ts_end = 0;
    vectors++; if (i_syn !== 32'd3) begin miscompares++; $display("FAIL sum_3 got %h exp 3", i_syn); end
    vectors++; if (i_valid !== 1'b1) begin miscompares++; $display("FAIL sum_3_valid got %b exp 1", i_valid); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_pulse got %b exp 0", rd_valid); end
    ready = 1; tick();
    ready = 0;
    vectors++; if (i_valid !== 1'b0) begin miscompares++; $display("FAIL consume_valid got %b exp 0", i_valid); end
    vectors++; if (i_syn !== 32'd3) begin miscompares++; $display("FAIL consume_hold got %h exp 3", i_syn); end
  endtask

  // Simultaneous write and read returns the new weight
  task automatic test_write_first;
    w_en = 1; r_en = 1; addr = 7'd9; data = 32'h0000_007F; tick();
    w_en = 0; r_en = 0;
    vectors++; if (rd_weight !== 8'h7F) begin miscompares++; $display("FAIL wf_rd got %h exp 7f", rd_weight); end
    ts_end = 1; tick();
    ts_end = 0;
    vectors++; if (i_syn !== 32'd127) begin miscompares++; $display("FAIL wf_sum got %h exp 7f", i_syn); end
    ready = 1; tick();
    ready = 0;
  endtask

  // Read in ts_end cycle belongs to the next timestep
  task automatic test_ts_boundary;
    r_en = 1; addr = 7'd3; tick();
    addr = 7'd4; ts_end = 1; tick();
    r_en = 0; ts_end = 0;
    vectors++; if (i_syn !== 32'd5) begin miscompares++; $display("FAIL boundary_5 got %h exp 5", i_syn); end
    ready = 1; tick();
    ready = 0;
    vectors++; if (i_valid !== 1'b0) begin miscompares++; $display("FAIL boundary_consume got %b exp 0", i_valid); end
    ts_end = 1; tick();
    ts_end = 0;
    vectors++; if (i_syn !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL boundary_m2 got %h exp fffffffe", i_syn); end
    vectors++; if (i_valid !== 1'b1) begin miscompares++; $display("FAIL boundary_m2_valid got %b exp 1", i_valid); end
  endtask

  // SOMA stalled: new sums dropped, held value stable, overrun sticky
  task automatic test_overrun;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_pre got %b exp 0", overrun); end
    r_en = 1; addr = 7'd3; tick();
    r_en = 0; ts_end = 1; tick();
    vectors++; if (i_syn !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL overrun_hold1 got %h exp fffffffe", i_syn); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set got %b exp 1", overrun); end
    tick();
    ts_end = 0;
    vectors++; if (i_syn !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL overrun_hold2 got %h exp fffffffe", i_syn); end
    vectors++; if (i_valid !== 1'b1) begin miscompares++; $display("FAIL overrun_valid got %b exp 1", i_valid); end
    ready = 1; tick();
    ready = 0;
    vectors++; if (i_valid !== 1'b0) begin miscompares++; $display("FAIL overrun_consume got %b exp 0", i_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky got %b exp 1", overrun); end
  endtask

  // 12-bit accumulator: 16*127=2032 fits, 17*127 clamps, 17*-128 clamps
  task automatic test_saturation;
    s_w = 1; s_addr = 7'd10; s_data = 32'h0000_007F; tick();
    s_addr = 7'd11; s_data = 32'h0000_0080; tick();
    s_w = 0;
    s_addr = 7'd10;
    for (int i = 0; i < 16; i++) begin s_r = 1; tick(); end
    s_r = 0; s_ts = 1; tick();
    s_ts = 0;
    vectors++; if (s_i_syn !== 12'h7F0) begin miscompares++; $display("FAIL sat_below got %h exp 7f0", s_i_syn); end
    for (int i = 0; i < 17; i++) begin s_r = 1; tick(); end
    s_r = 0; s_ts = 1; tick();
    s_ts = 0;
    vectors++; if (s_i_syn !== 12'h7FF) begin miscompares++; $display("FAIL sat_pos got %h exp 7ff", s_i_syn); end
    s_addr = 7'd11;
    for (int i = 0; i < 17; i++) begin s_r = 1; tick(); end
    s_r = 0; s_ts = 1; tick();
    s_ts = 0;
    vectors++; if (s_i_syn !== 12'h800) begin miscompares++; $display("FAIL sat_neg got %h exp 800", s_i_syn); end
    vectors++; if (s_overrun !== 1'b0) begin miscompares++; $display("FAIL sat_overrun got %b exp 0", s_overrun); end
  endtask

  // Async reset mid-flight clears outputs, drops pending weight, keeps RAM
  task automatic test_reset_midflight;
    r_en = 1; addr = 7'd3; tick();
    addr = 7'd4; ts_end = 1; tick();
    r_en = 0; ts_end = 0;
    vectors++; if (i_syn !== 32'd5) begin miscompares++; $display("FAIL mid_pre got %h exp 5", i_syn); end
    rst = 1; #1;
    vectors++; if (i_syn !== 32'd0) begin miscompares++; $display("FAIL mid_i_syn got %h exp 0", i_syn); end
    vectors++; if (i_valid !== 1'b0) begin miscompares++; $display("FAIL mid_i_valid got %b exp 0", i_valid); end
    vectors++; if (rd_weight !== 8'h00) begin miscompares++; $display("FAIL mid_rd_weight got %h exp 0", rd_weight); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rd_valid got %b exp 0", rd_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL mid_overrun got %b exp 0", overrun); end
    #1 rst = 0;
    tick();
    ts_end = 1; tick();
    ts_end = 0;
    vectors++; if (i_syn !== 32'd0) begin miscompares++; $display("FAIL mid_no_acc got %h exp 0", i_syn); end
    vectors++; if (i_valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid got %b exp 1", i_valid); end
    ready = 1; r_en = 1; addr = 7'd3; tick();
    vectors++; if (rd_weight !== 8'h05) begin miscompares++; $display("FAIL ram_keep3 got %h exp 05", rd_weight); end
    addr = 7'd4; tick();
    vectors++; if (rd_weight !== 8'hFE) begin miscompares++; $display("FAIL ram_keep4 got %h exp fe", rd_weight); end
    idle(); ready = 0; tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_first();
    test_ts_boundary();
    test_overrun();
    test_saturation();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
